match_result_collector: RTL

- Downstream of the single-grid X-stabilizer decoder top (GRID_Y x GRID_X nodes).
- After the decoder's stop_offer, snapshots every node's defect flag (measurement) and match_value_out in one cycle; the decoder can then be reset or reloaded.
- Scans the snapshot row-major and emits one record per defect node on a valid/ready stream to the correction/readout logic.
- Signals completion with a done pulse and a record count.

---
 rtl/match_result_collector_pkg.sv | 28 ++
 rtl/match_record_reg.sv | 31 +++
 rtl/match_result_collector.sv | 136 +++++++++++++
 3 files changed

// File: rtl/match_result_collector_pkg.sv
// Shared grid/record parameters, record layout and FSM encoding for the
// decoder match-result collector.
package match_result_collector_pkg;

  localparam int GRID_Y = 4;
  localparam int GRID_X = 5;
  localparam int CORDINATE_WIDTH = 3;
  localparam int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH;
  localparam int RECORD_WIDTH = 4 * CORDINATE_WIDTH;

  // Record layout: {node_y, node_x, match_y, match_x}
  localparam int MATCH_X_LSB = 0;
  localparam int MATCH_Y_LSB = CORDINATE_WIDTH;
  localparam int NODE_X_LSB = 2 * CORDINATE_WIDTH;
  localparam int NODE_Y_LSB = 3 * CORDINATE_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FIN
  } collector_state_t;

  function automatic int count_width(input int nodes);
    return $clog2(nodes + 1);
  endfunction

endpackage

// File: rtl/match_record_reg.sv
// One-entry valid/ready output register; load must only be
// asserted when the entry is empty or being transferred.
module match_record_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_flag,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flag  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_flag  <= in_flag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/match_result_collector.sv
// Snapshots decoder defects/matches and streams one record per defect.
// MATCH_COLLECTOR_DEDUP_PAIRS_EN: emit one record per in-grid matched pair.
module match_result_collector
  import match_result_collector_pkg::*;
#(
  parameter int GRID_Y = match_result_collector_pkg::GRID_Y,
  parameter int GRID_X = match_result_collector_pkg::GRID_X
) (
  input  logic clk,
  input  logic reset,
  input  logic [GRID_Y*GRID_X-1:0] measurement_flat,
  input  logic [GRID_Y*GRID_X*MATCH_VALUE_WIDTH-1:0] match_value_flat,
  input  logic capture,
  output logic out_valid,
  input  logic out_ready,
  output logic [RECORD_WIDTH-1:0] out_data,
  output logic out_boundary,
  output logic done,
  output logic [count_width(GRID_Y*GRID_X)-1:0] record_count,
  output logic busy,
  output logic capture_overrun
);

  localparam int CW = CORDINATE_WIDTH;
  localparam int MW = MATCH_VALUE_WIDTH;
  localparam int NODES = GRID_Y * GRID_X;
  localparam int IW = $clog2(NODES);

  collector_state_t state, state_nx;

  logic [NODES-1:0]    meas_q;
  logic [NODES*MW-1:0] match_q;
  logic [IW-1:0]       index;
  logic [CW-1:0]       node_y;
  logic [CW-1:0]       node_x;
  logic [MW-1:0]       cur_match;
  logic [CW-1:0]       cur_my;
  logic [CW-1:0]       cur_mx;
  logic [RECORD_WIDTH-1:0] rec_in;
  logic stall, scanning, last, boundary, keep, load;

  assign cur_match = match_q[int'(index)*MW +: MW];
  assign cur_my    = cur_match[MW-1 -: CW];
  assign cur_mx    = cur_match[CW-1:0];
  assign stall     = out_valid && !out_ready;
  assign scanning  = (state == SCAN) && !stall;
  assign last      = index == IW'(NODES - 1);
  assign boundary  = (cur_my >= CW'(GRID_Y)) || (cur_mx >= CW'(GRID_X));

`ifdef MATCH_COLLECTOR_DEDUP_PAIRS_EN
  int match_idx;
  assign match_idx = int'(cur_my) * GRID_X + int'(cur_mx);
  // Lower index of a pair reports; self-matches fall through as equal.
  assign keep = boundary || (int'(index) <= match_idx);
`else
  assign keep = 1'b1;
`endif

  assign load = scanning && meas_q[index] && keep;

  assign rec_in[NODE_Y_LSB +: CW]  = node_y;
  assign rec_in[NODE_X_LSB +: CW]  = node_x;
  assign rec_in[MATCH_Y_LSB +: CW] = cur_my;
  assign rec_in[MATCH_X_LSB +: CW] = cur_mx;

  assign busy = state != IDLE;
  assign done = state == FIN;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (capture) state_nx = SCAN;
      SCAN:    if (!stall && last) state_nx = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meas_q          <= '0;
      match_q         <= '0;
      index           <= '0;
      node_y          <= '0;
      node_x          <= '0;
      record_count    <= '0;
      capture_overrun <= 1'b0;
    end else begin
      if (capture && state != IDLE) capture_overrun <= 1'b1;
      if (capture && state == IDLE) begin
        meas_q       <= measurement_flat;
        match_q      <= match_value_flat;
        index        <= '0;
        node_y       <= '0;
        node_x       <= '0;
        record_count <= '0;
      end else if (scanning) begin
        if (last) begin
          index  <= '0;
          node_y <= '0;
          node_x <= '0;
        end else begin
          index <= index + 1'b1;
          if (node_x == CW'(GRID_X - 1)) begin
            node_x <= '0;
            node_y <= node_y + 1'b1;
          end else begin
            node_x <= node_x + 1'b1;
          end
        end
        if (load) record_count <= record_count + 1'b1;
      end
    end
  end

  match_record_reg #(
    .WIDTH(RECORD_WIDTH)
  ) u_rec (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .in_data  (rec_in),
    .in_flag  (boundary),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_flag (out_boundary)
  );

endmodule
